// File: rtl/counter_ctrl_pkg.sv
// Shared opcodes and controller state encoding for the counter sequencer.
package counter_ctrl_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Command handshake and status bundle between a host and the counter sequencer.
interface counter_seq_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int STEPW = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [STEPW-1:0] cmd_arg;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             wrapped;
    logic             aborted;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, abort,
        input  cmd_ready, count, busy, done, wrapped, aborted
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, abort,
        output cmd_ready, count, busy, done, wrapped, aborted
    );
endinterface

// File: rtl/updown_counter.sv
// Loadable up/down counter; load wins over en, wrap flags a step that rolls over.
module updown_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic             down,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] q,
    output logic             wrap
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= data_in;
        end else if (en) begin
            q <= down ? q - WIDTH'(1) : q + WIDTH'(1);
        end
    end

    assign wrap = en & (down ? (q == '0) : (q == '1));

endmodule

// File: rtl/counter_seq_ctrl.sv
// Command sequencer: accepts one command in IDLE, steps the counter in EXEC,
// then pulses done for one cycle in DONE.
module counter_seq_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int STEPW = 8
) (
    input  logic                clk,
    input  logic                rst,
    counter_seq_ctrl_if.slave   bus
);

    state_t           state_reg, state_next;
    logic [1:0]       op_reg, op_next;
    logic [WIDTH-1:0] load_val_reg, load_val_next;
    logic [STEPW-1:0] remaining_reg, remaining_next;
    logic             wrapped_reg, wrapped_next;
    logic             aborted_reg, aborted_next;

    logic             ctr_load;
    logic             ctr_en;
    logic             ctr_down;
    logic [WIDTH-1:0] ctr_data;
    logic [WIDTH-1:0] ctr_q;
    logic             ctr_wrap;

    updown_counter #(.WIDTH(WIDTH)) u_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (ctr_load),
        .en      (ctr_en),
        .down    (ctr_down),
        .data_in (ctr_data),
        .q       (ctr_q),
        .wrap    (ctr_wrap)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            op_reg        <= OP_LOAD;
            load_val_reg  <= '0;
            remaining_reg <= '0;
            wrapped_reg   <= 1'b0;
            aborted_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            load_val_reg  <= load_val_next;
            remaining_reg <= remaining_next;
            wrapped_reg   <= wrapped_next;
            aborted_reg   <= aborted_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        op_next        = op_reg;
        load_val_next  = load_val_reg;
        remaining_next = remaining_reg;
        wrapped_next   = wrapped_reg;
        aborted_next   = aborted_reg;
        ctr_load       = 1'b0;
        ctr_en         = 1'b0;
        ctr_down       = (op_reg == OP_DOWN);
        ctr_data       = load_val_reg;

        case (state_reg)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    op_next        = bus.cmd_op;
                    load_val_next  = bus.cmd_arg[WIDTH-1:0];
                    remaining_next = bus.cmd_arg;
                    wrapped_next   = 1'b0;
                    aborted_next   = 1'b0;
                    state_next     = S_EXEC;
                end
            end
            S_EXEC: begin
                // Abort suppresses any step or load on the same edge.
                if (bus.abort) begin
                    aborted_next = 1'b1;
                    state_next   = S_DONE;
                end else begin
                    case (op_reg)
                        OP_LOAD: begin
                            ctr_load   = 1'b1;
                            state_next = S_DONE;
                        end
                        OP_CLEAR: begin
                            ctr_load   = 1'b1;
                            ctr_data   = '0;
                            state_next = S_DONE;
                        end
                        OP_UP, OP_DOWN: begin
                            if (remaining_reg == '0) begin
                                state_next = S_DONE;
                            end else begin
                                ctr_en         = 1'b1;
                                remaining_next = remaining_reg - STEPW'(1);
                                if (ctr_wrap) begin
                                    wrapped_next = 1'b1;
                                end
                                if (remaining_reg == STEPW'(1)) begin
                                    state_next = S_DONE;
                                end
                            end
                        end
                    endcase
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign bus.count     = ctr_q;
    assign bus.cmd_ready = (state_reg == S_IDLE);
    assign bus.busy      = (state_reg == S_EXEC) || (state_reg == S_DONE);
    assign bus.done      = (state_reg == S_DONE);
    assign bus.wrapped   = wrapped_reg;
    assign bus.aborted   = aborted_reg;

endmodule
